// File: rtl/seq_multiplier_hs.sv
// Shift-add sequential multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes at capture; the sign is
// reapplied to the finished accumulator, so the datapath itself is unsigned.
module seq_multiplier_hs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic                 neg_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   product_d;

    // Operand magnitudes at capture and the accumulator / result for this step
    always_comb begin
        mag_a_d   = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b_d   = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_d     = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        product_d = neg_q ? -acc_d : acc_d;
    end

    // Control FSM and shift-add datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                        mplier_q <= mag_b_d;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        neg_q    <= neg_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    mcand_q  <= mcand_q << 1;
                    cnt_q    <= cnt_q - CW'(1);
                    // last step: result taken from this step's sum, not acc_q
                    if (cnt_q == CW'(1)) begin
                        product_q <= product_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule
